// File: rtl/block_buffer_ring_if.sv
// rtl/block_buffer_ring_if.sv - producer/consumer client bus of block_buffer_ring.
// BLOCK_BUF_PERF_EN adds the stall/starve counter outputs.
interface block_buffer_ring_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] prod_address;
    logic [DATA_W-1:0] prod_write_data;
    logic              prod_write_enable;
    logic [DATA_W-1:0] prod_read_data;
    logic              prod_block_done;
    logic              prod_ready;
    logic [ADDR_W-1:0] cons_address_a;
    logic [ADDR_W-1:0] cons_address_b;
    logic [DATA_W-1:0] cons_write_data_a;
    logic [DATA_W-1:0] cons_write_data_b;
    logic              cons_write_enable_a;
    logic              cons_write_enable_b;
    logic [DATA_W-1:0] cons_read_data_a;
    logic [DATA_W-1:0] cons_read_data_b;
    logic              cons_block_done;
    logic              cons_valid;
    logic [3:0]        bank_count;
    logic              frame_done;
    logic              overflow_err;
    logic              underflow_err;
`ifdef BLOCK_BUF_PERF_EN
    logic [23:0]       prod_stall_cycles;
    logic [23:0]       cons_starve_cycles;

    modport master (
        output prod_address, prod_write_data, prod_write_enable, prod_block_done,
        output cons_address_a, cons_address_b, cons_write_data_a, cons_write_data_b,
        output cons_write_enable_a, cons_write_enable_b, cons_block_done,
        input  prod_read_data, prod_ready, cons_read_data_a, cons_read_data_b,
        input  cons_valid, bank_count, frame_done, overflow_err, underflow_err,
        input  prod_stall_cycles, cons_starve_cycles
    );
    modport slave (
        input  prod_address, prod_write_data, prod_write_enable, prod_block_done,
        input  cons_address_a, cons_address_b, cons_write_data_a, cons_write_data_b,
        input  cons_write_enable_a, cons_write_enable_b, cons_block_done,
        output prod_read_data, prod_ready, cons_read_data_a, cons_read_data_b,
        output cons_valid, bank_count, frame_done, overflow_err, underflow_err,
        output prod_stall_cycles, cons_starve_cycles
    );
`else
    modport master (
        output prod_address, prod_write_data, prod_write_enable, prod_block_done,
        output cons_address_a, cons_address_b, cons_write_data_a, cons_write_data_b,
        output cons_write_enable_a, cons_write_enable_b, cons_block_done,
        input  prod_read_data, prod_ready, cons_read_data_a, cons_read_data_b,
        input  cons_valid, bank_count, frame_done, overflow_err, underflow_err
    );
    modport slave (
        input  prod_address, prod_write_data, prod_write_enable, prod_block_done,
        input  cons_address_a, cons_address_b, cons_write_data_a, cons_write_data_b,
        input  cons_write_enable_a, cons_write_enable_b, cons_block_done,
        output prod_read_data, prod_ready, cons_read_data_a, cons_read_data_b,
        output cons_valid, bank_count, frame_done, overflow_err, underflow_err
    );
`endif
endinterface

// File: rtl/block_buffer_ring.sv
// rtl/block_buffer_ring.sv - ring of NUM_BANKS dual-port RAM banks between block producer and consumer.
// Optional BLOCK_BUF_PERF_EN adds saturating producer-stall / consumer-starve cycle counters.
module block_buffer_ring #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 7,
    parameter int NUM_BANKS    = 2,
    parameter int TOTAL_BLOCKS = 2400
) (
    input  logic               CLOCK_50_I,
    input  logic               reset,
    block_buffer_ring_if.slave bus
);
    localparam int PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_W = $clog2(NUM_BANKS + 1);
    localparam int BLK_W = $clog2(TOTAL_BLOCKS + 1);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BANKS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BANKS);
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(TOTAL_BLOCKS - 1);

    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [BLK_W-1:0] r_blk_cnt;
    logic             r_frame_done, r_overflow, r_underflow;
    logic [PTR_W-1:0] r_prod_rd_ptr, r_cons_rd_ptr;
    logic             r_prod_rd_ok, r_cons_b_ok;

    logic w_prod_ready, w_cons_valid, w_shared;
    logic w_prod_owns_b, w_cons_owns_b;
    logic w_prod_we, w_cons_we_a, w_cons_we_b;
    logic w_prod_acc, w_cons_acc, w_prod_ovf, w_cons_unf;
    logic [DATA_W-1:0] w_q_a [NUM_BANKS];
    logic [DATA_W-1:0] w_q_b [NUM_BANKS];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_prod_ready = (r_count < FULL_CNT);
    assign w_cons_valid = (r_count != '0);
    assign w_shared     = (r_wr_ptr == r_rd_ptr);
    // Equal pointers mean the ring is empty or full; that decides who owns port B.
    assign w_prod_owns_b = !w_shared || w_prod_ready;
    assign w_cons_owns_b = !w_shared || w_cons_valid;

    assign w_prod_we   = bus.prod_write_enable && w_prod_ready;
    assign w_cons_we_a = bus.cons_write_enable_a && w_cons_valid;
    assign w_cons_we_b = bus.cons_write_enable_b && w_cons_valid;

    assign w_prod_acc = bus.prod_block_done && w_prod_ready && !r_frame_done;
    assign w_prod_ovf = bus.prod_block_done && !w_prod_ready && !r_frame_done;
    assign w_cons_acc = bus.cons_block_done && w_cons_valid && !r_frame_done;
    assign w_cons_unf = bus.cons_block_done && !w_cons_valid && !r_frame_done;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [DATA_W-1:0] r_q_a, r_q_b;
        logic              w_is_wr, w_is_rd, w_b_prod, w_we_a, w_we_b;
        logic [ADDR_W-1:0] w_addr_b;
        logic [DATA_W-1:0] w_wdata_b;

        assign w_is_wr   = (r_wr_ptr == PTR_W'(b));
        assign w_is_rd   = (r_rd_ptr == PTR_W'(b));
        assign w_b_prod  = w_is_wr && w_prod_owns_b;
        assign w_addr_b  = w_b_prod ? bus.prod_address : bus.cons_address_b;
        assign w_wdata_b = w_b_prod ? bus.prod_write_data : bus.cons_write_data_b;
        assign w_we_a    = w_is_rd && w_cons_we_a;
        assign w_we_b    = w_b_prod ? w_prod_we : (w_is_rd && w_cons_we_b);

        always_ff @(posedge CLOCK_50_I) begin
            if (w_we_a)
                r_mem[bus.cons_address_a] <= bus.cons_write_data_a;
            if (w_we_b)
                r_mem[w_addr_b] <= w_wdata_b;
            if (reset) begin
                r_q_a <= '0;
                r_q_b <= '0;
            end else begin
                r_q_a <= r_mem[bus.cons_address_a];
                r_q_b <= r_mem[w_addr_b];
            end
        end

        assign w_q_a[b] = r_q_a;
        assign w_q_b[b] = r_q_b;
    end

    // Read muxes follow the pointer captured with the address, not the live pointer.
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            r_prod_rd_ptr <= '0;
            r_cons_rd_ptr <= '0;
            r_prod_rd_ok  <= 1'b0;
            r_cons_b_ok   <= 1'b0;
        end else begin
            r_prod_rd_ptr <= r_wr_ptr;
            r_cons_rd_ptr <= r_rd_ptr;
            r_prod_rd_ok  <= w_prod_owns_b;
            r_cons_b_ok   <= w_cons_owns_b;
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_blk_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_prod_acc)
                r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_cons_acc) begin
                r_rd_ptr  <= next_ptr(r_rd_ptr);
                r_blk_cnt <= r_blk_cnt + BLK_W'(1);
                if (r_blk_cnt == LAST_BLK)
                    r_frame_done <= 1'b1;
            end
            case ({w_prod_acc, w_cons_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_prod_ovf)
                r_overflow <= 1'b1;
            if (w_cons_unf)
                r_underflow <= 1'b1;
        end
    end

    assign bus.prod_read_data   = r_prod_rd_ok ? w_q_b[r_prod_rd_ptr] : '0;
    assign bus.cons_read_data_a = w_q_a[r_cons_rd_ptr];
    assign bus.cons_read_data_b = r_cons_b_ok ? w_q_b[r_cons_rd_ptr] : '0;
    assign bus.prod_ready       = w_prod_ready;
    assign bus.cons_valid       = w_cons_valid;
    assign bus.bank_count       = 4'(r_count);
    assign bus.frame_done       = r_frame_done;
    assign bus.overflow_err     = r_overflow;
    assign bus.underflow_err    = r_underflow;

`ifdef BLOCK_BUF_PERF_EN
    logic [23:0] r_prod_stall, r_cons_starve;

    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            r_prod_stall  <= '0;
            r_cons_starve <= '0;
        end else begin
            if (!w_prod_ready && !r_frame_done && (r_prod_stall != '1))
                r_prod_stall <= r_prod_stall + 24'd1;
            if (!w_cons_valid && !r_frame_done && (r_cons_starve != '1))
                r_cons_starve <= r_cons_starve + 24'd1;
        end
    end

    assign bus.prod_stall_cycles  = r_prod_stall;
    assign bus.cons_starve_cycles = r_cons_starve;
`endif
endmodule

// File: tb/tb_block_buffer_ring.sv
// tb/tb_block_buffer_ring.sv - self-checking bench for block_buffer_ring (2-bank data path, 3-bank frame control).
module tb_block_buffer_ring;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    block_buffer_ring_if #(.DATA_W(32), .ADDR_W(7)) bus_a ();
    block_buffer_ring_if #(.DATA_W(32), .ADDR_W(7)) bus_b ();

    block_buffer_ring #(.DATA_W(32), .ADDR_W(7), .NUM_BANKS(2), .TOTAL_BLOCKS(2400)) dut_a (
        .CLOCK_50_I(clk), .reset(rst_a), .bus(bus_a)
    );
    block_buffer_ring #(.DATA_W(32), .ADDR_W(7), .NUM_BANKS(3), .TOTAL_BLOCKS(4)) dut_b (
        .CLOCK_50_I(clk), .reset(rst_b), .bus(bus_b)
    );

    typedef struct {
        logic       rst, pd, cd;
        logic       rdy, vld;
        logic [3:0] cnt;
        logic       ovf, unf, fd;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic add(input logic r, p, c, rdy, vld, input int cnt, input logic o, u, f);
        vt.push_back('{r, p, c, rdy, vld, 4'(cnt), o, u, f});
    endtask

    task automatic flags_a(input string tag, input logic rdy, vld, input int cnt, input logic o, u);
        chk({tag, " prod_ready"}, 32'(bus_a.prod_ready), 32'(rdy));
        chk({tag, " cons_valid"}, 32'(bus_a.cons_valid), 32'(vld));
        chk({tag, " bank_count"}, 32'(bus_a.bank_count), 32'(cnt));
        chk({tag, " overflow"}, 32'(bus_a.overflow_err), 32'(o));
        chk({tag, " underflow"}, 32'(bus_a.underflow_err), 32'(u));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.prod_address = '0;        bus_b.prod_address = '0;
        bus_a.prod_write_data = '0;     bus_b.prod_write_data = '0;
        bus_a.prod_write_enable = 0;    bus_b.prod_write_enable = 0;
        bus_a.prod_block_done = 0;      bus_b.prod_block_done = 0;
        bus_a.cons_address_a = '0;      bus_b.cons_address_a = '0;
        bus_a.cons_address_b = '0;      bus_b.cons_address_b = '0;
        bus_a.cons_write_data_a = '0;   bus_b.cons_write_data_a = '0;
        bus_a.cons_write_data_b = '0;   bus_b.cons_write_data_b = '0;
        bus_a.cons_write_enable_a = 0;  bus_b.cons_write_enable_a = 0;
        bus_a.cons_write_enable_b = 0;  bus_b.cons_write_enable_b = 0;
        bus_a.cons_block_done = 0;      bus_b.cons_block_done = 0;
        rst_a = 1; rst_b = 1;
        step(); step();
        rst_a = 0; rst_b = 0;

        // Reset state, 2-bank instance
        flags_a("reset", 1, 0, 0, 0, 0);
        chk("reset prod_rd", bus_a.prod_read_data, 32'h0);
        chk("reset cons_rd_a", bus_a.cons_read_data_a, 32'h0);
        chk("reset cons_rd_b", bus_a.cons_read_data_b, 32'h0);

        // Fill bank 0 and hand it over
        for (int a = 0; a < 128; a++) begin
            bus_a.prod_address = 7'(a);
            bus_a.prod_write_data = 32'hA5A5_0000 + 32'(a);
            bus_a.prod_write_enable = 1;
            step();
        end
        bus_a.prod_write_enable = 0;
        bus_a.prod_block_done = 1; step(); bus_a.prod_block_done = 0;
        flags_a("done1", 1, 1, 1, 0, 0);
        bus_a.cons_address_a = 7'd5; bus_a.cons_address_b = 7'd7; step();
        chk("cons_a addr5", bus_a.cons_read_data_a, 32'hA5A5_0005);
        chk("cons_b addr7", bus_a.cons_read_data_b, 32'hA5A5_0007);

        // Fill part of bank 1, ring becomes full
        for (int a = 0; a < 4; a++) begin
            bus_a.prod_address = 7'(a);
            bus_a.prod_write_data = 32'hB000_0000 + 32'(a);
            bus_a.prod_write_enable = 1;
            step();
        end
        bus_a.prod_write_enable = 0;
        bus_a.prod_block_done = 1; step(); bus_a.prod_block_done = 0;
        flags_a("full", 0, 1, 2, 0, 0);

        // Dropped producer write into the consumer-owned bank 0
        bus_a.prod_address = 7'd0; bus_a.prod_write_data = 32'h0000_DEAD;
        bus_a.prod_write_enable = 1; step(); bus_a.prod_write_enable = 0;
        chk("full prod_rd zero", bus_a.prod_read_data, 32'h0);
        bus_a.cons_address_a = 7'd0; bus_a.cons_address_b = 7'd1; step();
        chk("bank0 addr0 kept", bus_a.cons_read_data_a, 32'hA5A5_0000);
        chk("full cons_b owns", bus_a.cons_read_data_b, 32'hA5A5_0001);

        bus_a.prod_block_done = 1; step(); bus_a.prod_block_done = 0;
        flags_a("overflow", 0, 1, 2, 1, 0);

        bus_a.cons_block_done = 1; step(); bus_a.cons_block_done = 0;
        flags_a("cons1", 1, 1, 1, 1, 0);
        bus_a.cons_address_a = 7'd2; step();
        chk("bank1 addr2", bus_a.cons_read_data_a, 32'hB000_0002);

        // Simultaneous done pulses: both pointers move, count holds
        bus_a.prod_block_done = 1; bus_a.cons_block_done = 1; step();
        bus_a.prod_block_done = 0; bus_a.cons_block_done = 0;
        flags_a("both", 1, 1, 1, 1, 0);
        bus_a.cons_address_a = 7'd3; bus_a.prod_address = 7'd2; step();
        chk("both rd_ptr->0", bus_a.cons_read_data_a, 32'hA5A5_0003);
        chk("both wr_ptr->1", bus_a.prod_read_data, 32'hB000_0002);

        bus_a.cons_block_done = 1; step();
        flags_a("empty", 1, 0, 0, 1, 0);
        step(); bus_a.cons_block_done = 0;
        flags_a("underflow", 1, 0, 0, 1, 1);

        // Empty shared bank: consumer port B reads 0, consumer writes dropped
        bus_a.cons_address_b = 7'd2; step();
        chk("empty cons_b zero", bus_a.cons_read_data_b, 32'h0);
        bus_a.cons_address_a = 7'd2; bus_a.cons_write_data_a = 32'hFFFF_FFFF;
        bus_a.cons_write_enable_a = 1; step(); bus_a.cons_write_enable_a = 0;
        bus_a.prod_address = 7'd2; step();
        chk("cons write dropped", bus_a.prod_read_data, 32'hB000_0002);

        rst_a = 1; step(); rst_a = 0;
        flags_a("midreset", 1, 0, 0, 0, 0);
        chk("midreset prod_rd", bus_a.prod_read_data, 32'h0);
        chk("midreset cons_rd_a", bus_a.cons_read_data_a, 32'h0);

        // 3-bank, 4-block frame control table
        //   rst pd cd  rdy vld cnt ovf unf fd
        add(0, 0, 1,  1, 0, 0,  0, 1, 0);
        add(0, 1, 0,  1, 1, 1,  0, 1, 0);
        add(0, 1, 0,  1, 1, 2,  0, 1, 0);
        add(0, 1, 0,  0, 1, 3,  0, 1, 0);
        add(0, 1, 0,  0, 1, 3,  1, 1, 0);
        add(0, 0, 1,  1, 1, 2,  1, 1, 0);
        add(0, 1, 1,  1, 1, 2,  1, 1, 0);
        add(0, 0, 1,  1, 1, 1,  1, 1, 0);
        add(0, 0, 0,  1, 1, 1,  1, 1, 0);
        add(0, 0, 1,  1, 0, 0,  1, 1, 1);
        add(0, 1, 0,  1, 0, 0,  1, 1, 1);
        add(0, 0, 0,  1, 0, 0,  1, 1, 1);
        add(1, 0, 0,  1, 0, 0,  0, 0, 0);
        add(0, 1, 0,  1, 1, 1,  0, 0, 0);
        add(0, 0, 1,  1, 0, 0,  0, 0, 0);
        add(0, 1, 0,  1, 1, 1,  0, 0, 0);
        add(0, 0, 1,  1, 0, 0,  0, 0, 0);
        add(0, 1, 0,  1, 1, 1,  0, 0, 0);
        add(1, 0, 0,  1, 0, 0,  0, 0, 0);
        add(0, 1, 0,  1, 1, 1,  0, 0, 0);
        add(0, 0, 1,  1, 0, 0,  0, 0, 0);
        add(0, 1, 0,  1, 1, 1,  0, 0, 0);
        add(0, 1, 1,  1, 1, 1,  0, 0, 0);
        add(0, 1, 1,  1, 1, 1,  0, 0, 0);
        add(0, 1, 0,  1, 1, 2,  0, 0, 0);
        add(0, 0, 1,  1, 1, 1,  0, 0, 1);
        add(0, 0, 1,  1, 1, 1,  0, 0, 1);
        add(0, 1, 0,  1, 1, 1,  0, 0, 1);
        add(1, 0, 0,  1, 0, 0,  0, 0, 0);
        add(0, 0, 1,  1, 0, 0,  0, 1, 0);
        add(0, 1, 0,  1, 1, 1,  0, 1, 0);
        add(0, 0, 1,  1, 0, 0,  0, 1, 0);
        add(0, 1, 0,  1, 1, 1,  0, 1, 0);
        add(0, 0, 1,  1, 0, 0,  0, 1, 0);
        add(0, 1, 0,  1, 1, 1,  0, 1, 0);
        add(0, 0, 1,  1, 0, 0,  0, 1, 0);
        add(0, 1, 0,  1, 1, 1,  0, 1, 0);
        add(0, 0, 1,  1, 0, 0,  0, 1, 1);

        for (int i = 0; i < vt.size(); i++) begin
            rst_b = vt[i].rst;
            bus_b.prod_block_done = vt[i].pd;
            bus_b.cons_block_done = vt[i].cd;
            step();
            rst_b = 0;
            bus_b.prod_block_done = 0;
            bus_b.cons_block_done = 0;
            chk($sformatf("v%0d prod_ready", i), 32'(bus_b.prod_ready), 32'(vt[i].rdy));
            chk($sformatf("v%0d cons_valid", i), 32'(bus_b.cons_valid), 32'(vt[i].vld));
            chk($sformatf("v%0d bank_count", i), 32'(bus_b.bank_count), 32'(vt[i].cnt));
            chk($sformatf("v%0d overflow", i), 32'(bus_b.overflow_err), 32'(vt[i].ovf));
            chk($sformatf("v%0d underflow", i), 32'(bus_b.underflow_err), 32'(vt[i].unf));
            chk($sformatf("v%0d frame_done", i), 32'(bus_b.frame_done), 32'(vt[i].fd));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
